// File: rtl/mux_reduce_pkg.sv
// Shared types for the mux-built reduction pipeline.
package mux_reduce_pkg;

    typedef enum logic [1:0] {
        OP_OR    = 2'b00,
        OP_AND   = 2'b01,
        OP_XOR   = 2'b10,
        OP_PASS0 = 2'b11
    } reduce_op_t;

endpackage

// File: rtl/mux_op_cell.sv
// Combinational two-word reduction cell: every gate, including the op select,
// is a 2:1 mux fed by the operands or the constants 0/1.
module mux_reduce_mux2 (
    input  logic s,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = s ? d1 : d0;
endmodule

module mux_op_cell
    import mux_reduce_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  reduce_op_t   op,
    output logic [W-1:0] y
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic or_y, and_y, not_a, xor_y, lo_y, hi_y;

        mux_reduce_mux2 u_or  (.s(b[i]), .d0(a[i]), .d1(1'b1),  .y(or_y));
        mux_reduce_mux2 u_and (.s(b[i]), .d0(1'b0), .d1(a[i]),  .y(and_y));
        // Inverter as a mux selecting between the constants.
        mux_reduce_mux2 u_not (.s(a[i]), .d0(1'b1), .d1(1'b0),  .y(not_a));
        mux_reduce_mux2 u_xor (.s(b[i]), .d0(a[i]), .d1(not_a), .y(xor_y));

        // op[0] picks within {OR,AND} and {XOR,PASS0}; op[1] picks the pair.
        mux_reduce_mux2 u_lo  (.s(op[0]), .d0(or_y),  .d1(and_y), .y(lo_y));
        mux_reduce_mux2 u_hi  (.s(op[0]), .d0(xor_y), .d1(a[i]),  .y(hi_y));
        mux_reduce_mux2 u_sel (.s(op[1]), .d0(lo_y),  .d1(hi_y),  .y(y[i]));
    end
endmodule

// File: rtl/mux_reduce_pipe.sv
// Pipelined N_CH-channel bitwise reduction: one balanced tree level of
// mux_op_cell per register stage, valid/ready on both sides.
module mux_reduce_pipe
    import mux_reduce_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [N_CH*W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_op,
    output logic [W-1:0]    out_data
);
    localparam int LEVELS = $clog2(N_CH);
    // Tree words stored heap-style: level k starts at N_CH - (N_CH >> k).
    localparam int NWORDS = N_CH - 1;

    // Handshake: a side transfers on a rising edge where valid && ready.
    // Producers hold valid/op/data until transfer; in_ready depends only on
    // out_ready and stage valids, never on in_valid. A full stage advances when
    // the stage after it advances or is empty, so bubbles close up under stall.

    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] src_valid;
    logic [LEVELS-1:0] adv;
    reduce_op_t        op_q   [LEVELS];
    reduce_op_t        op_src [LEVELS];
    logic [W-1:0]      word_q   [NWORDS];
    logic [W-1:0]      word_nxt [NWORDS];
    logic [NWORDS-1:0] word_ld;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int DST   = N_CH - (N_CH >> k);
        localparam int NPAIR = N_CH >> (k + 1);

        if (k == 0) begin : g_src_in
            assign src_valid[k] = in_valid;
            assign op_src[k]    = reduce_op_t'(in_op);
        end else begin : g_src_stage
            assign src_valid[k] = valid_q[k-1];
            assign op_src[k]    = op_q[k-1];
        end

        for (genvar j = 0; j < NPAIR; j++) begin : g_pair
            logic [W-1:0] a, b;

            if (k == 0) begin : g_in
                assign a = in_data[(2*j)*W +: W];
                assign b = in_data[(2*j+1)*W +: W];
            end else begin : g_prev
                localparam int SRC = N_CH - (N_CH >> (k - 1));
                assign a = word_q[SRC + 2*j];
                assign b = word_q[SRC + 2*j + 1];
            end

            mux_op_cell #(.W(W)) u_cell (
                .a  (a),
                .b  (b),
                .op (op_src[k]),
                .y  (word_nxt[DST + j])
            );

            assign word_ld[DST + j] = adv[k] & src_valid[k];
        end
    end

    // adv[k] is set unless stages k..LEVELS-1 are all full and the output stalls.
    always_comb begin : adv_chain
        logic full;
        full = 1'b1;
        adv  = '0;
        for (int k = LEVELS - 1; k >= 0; k--) begin
            full   = full & valid_q[k];
            adv[k] = out_ready | ~full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < LEVELS; k++) op_q[k] <= OP_OR;
            for (int i = 0; i < NWORDS; i++) word_q[i] <= '0;
        end else begin
            for (int k = 0; k < LEVELS; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) op_q[k] <= op_src[k];
                end
            end
            for (int i = 0; i < NWORDS; i++) begin
                if (word_ld[i]) word_q[i] <= word_nxt[i];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[LEVELS-1];
    assign out_op    = op_q[LEVELS-1];
    assign out_data  = word_q[NWORDS-1];

endmodule
